// File: rtl/mem_request_scheduler.sv
// mem_request_scheduler: round-robin memory request arbiter with critical priority and a one-entry output hold register
//   clk_in                      : clock, all state on rising edge
//   reset_in                    : asynchronous active-high reset
//   request_flatted_in          : NUM_REQUEST packets, requester i at [i*W +: W]
//   request_valid_flatted_in    : per-requester valid
//   request_critical_flatted_in : per-requester critical hint
//   issue_ack_out               : one-hot grant pulse (combinational, grant cycle)
//   request_out                 : registered granted packet, zero while empty
//   request_valid_out           : request_out holds a packet
//   issue_ack_in                : downstream accepted request_out
// Optional macro MEM_REQUEST_SCHEDULER_STARVATION_GUARD_EN adds per-requester wait
// counters that promote a requester to critical after STARVATION_LIMIT ungranted cycles.
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif
module mem_request_scheduler #(
  parameter int NUM_REQUEST = 8,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int STARVATION_LIMIT = 15
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_in,
  input  logic [NUM_REQUEST-1:0] request_valid_flatted_in,
  input  logic [NUM_REQUEST-1:0] request_critical_flatted_in,
  output logic [NUM_REQUEST-1:0] issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_out,
  output logic request_valid_out,
  input  logic issue_ack_in
);
  localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int PW = NUM_REQUEST > 1 ? $clog2(NUM_REQUEST) : 1;
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state, state_next;
  logic [PW-1:0] ptr, pick;
  logic [NUM_REQUEST-1:0] crit, sel;
  logic grant;
  // Scan from ptr+N down to ptr+1 so the nearest index above ptr overwrites the rest;
  // ptr itself (k == N) is the last resort.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQUEST-1:0] s, input logic [PW-1:0] p);
    logic [PW-1:0] r;
    int j;
    r = p;
    for (int k = NUM_REQUEST; k >= 1; k--) begin
      j = int'(p) + k;
      if (j >= NUM_REQUEST) j -= NUM_REQUEST;
      if (s[PW'(j)]) r = PW'(j);
    end
    return r;
  endfunction
`ifdef MEM_REQUEST_SCHEDULER_STARVATION_GUARD_EN
  localparam int CW = $clog2(STARVATION_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVATION_LIMIT);
  logic [NUM_REQUEST-1:0] starved;
  for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_cnt
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_in or posedge reset_in)
      if (reset_in) cnt <= '0;
      else cnt <= (!request_valid_flatted_in[i] || issue_ack_out[i]) ? '0 : (cnt == LIM) ? cnt : cnt + 1'b1;
    assign starved[i] = cnt == LIM;
  end
  assign crit = (request_critical_flatted_in | starved) & request_valid_flatted_in;
`else
  assign crit = request_critical_flatted_in & request_valid_flatted_in;
`endif
  assign sel = |crit ? crit : request_valid_flatted_in;
  assign pick = rr_pick(sel, ptr);
  // Reset also masks the combinational grant so no ack escapes while reset is held.
  assign grant = !reset_in && |request_valid_flatted_in && (state == EMPTY || issue_ack_in);
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) state <= EMPTY;
    else state <= state_next;
  always_comb begin
    state_next = grant ? HOLD : (state == HOLD && issue_ack_in) ? EMPTY : state;
    issue_ack_out = grant ? NUM_REQUEST'(1) << pick : '0;
    request_valid_out = state == HOLD;
  end
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      ptr <= PW'(NUM_REQUEST - 1);
      request_out <= '0;
    end else begin
      if (grant) ptr <= pick;
      request_out <= grant ? request_flatted_in[pick*W +: W] : (state_next == EMPTY) ? '0 : request_out;
    end
endmodule

// File: tb/tb_mem_request_scheduler.sv
// tb_mem_request_scheduler: randomized + directed scoreboard bench against a behavioural arbiter model
module tb_mem_request_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LIM = 3;
  logic clk_in = 1'b0;
  logic reset_in;
  logic [N*W-1:0] pkts;
  logic [N-1:0] valid, crit, ack_out;
  logic [W-1:0] req_out;
  logic req_valid, ack_in;
  mem_request_scheduler #(.NUM_REQUEST(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W), .STARVATION_LIMIT(LIM)) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_flatted_in(pkts),
    .request_valid_flatted_in(valid),
    .request_critical_flatted_in(crit),
    .issue_ack_out(ack_out),
    .request_out(req_out),
    .request_valid_out(req_valid),
    .issue_ack_in(ack_in)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic [N-1:0] ack;
    logic vout;
    logic [W-1:0] dout;
    string tag;
  } exp_t;
  exp_t sb[$];
  event ev;
  int compared = 0;
  int mismatched = 0;
  bit m_held;
  logic [W-1:0] m_data;
  int m_ptr;
  int m_wait[N];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_held = 0;
    m_data = '0;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask
  // One cycle: drive inputs, predict this cycle's outputs, then advance the model past the edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] c, input logic a, input string tag, input int p0 = -1);
    exp_t e;
    logic [N-1:0] set;
    int g, idx;
    @(negedge clk_in);
    valid = v;
    crit = c;
    ack_in = a;
    for (int i = 0; i < N; i++) pkts[i*W +: W] = W'($urandom);
    if (p0 >= 0) pkts[W-1:0] = W'(p0);
    set = c & v;
`ifdef MEM_REQUEST_SCHEDULER_STARVATION_GUARD_EN
    for (int i = 0; i < N; i++) if (v[i] && m_wait[i] >= LIM) set[i] = 1'b1;
`endif
    if (set == '0) set = v;
    g = -1;
    if (set != '0 && (!m_held || a))
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && ((set >> idx) & 1) != 0) g = idx;
      end
    e.ack = (g < 0) ? '0 : N'(1) << g;
    e.vout = m_held;
    e.dout = m_data;
    e.tag = tag;
    sb.push_back(e);
    ->ev;
    for (int i = 0; i < N; i++)
      m_wait[i] = (v[i] && i != g) ? ((m_wait[i] < LIM) ? m_wait[i] + 1 : LIM) : 0;
    if (g >= 0) begin
      m_held = 1;
      m_data = pkts[g*W +: W];
      m_ptr = g;
    end else if (m_held && a) begin
      m_held = 0;
      m_data = '0;
    end
  endtask
  initial forever begin
    exp_t e;
    @ev;
    #2;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, " ack"}, 32'(ack_out), 32'(e.ack));
      check({e.tag, " valid"}, 32'(req_valid), 32'(e.vout));
      check({e.tag, " data"}, 32'(req_out), 32'(e.dout));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    reset_in = 1;
    valid = '0;
    crit = '0;
    ack_in = 0;
    pkts = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check("reset valid", 32'(req_valid), 0);
    check("reset data", 32'(req_out), 0);
    check("reset ack", 32'(ack_out), 0);
    reset_in = 0;
    repeat (4) step(4'b0101, 4'b0000, 1, "rr0101");
    step(4'b1111, 4'b1000, 1, "crit3");
    repeat (3) step(4'b1111, 4'b0000, 1, "rr_after_crit");
    step(4'b0001, 4'b0000, 1, "load_a5", 'hA5);
    repeat (5) step(4'b0001, 4'b0000, 0, "hold_a5");
    step(4'b0010, 4'b0000, 1, "b2b");
    step(4'b0000, 4'b0000, 0, "b2b_after");
    @(negedge clk_in);
    valid = '1;
    ack_in = 0;
    #1 reset_in = 1;
    #1;
    check("rst_mid valid", 32'(req_valid), 0);
    check("rst_mid data", 32'(req_out), 0);
    check("rst_mid ack", 32'(ack_out), 0);
    @(negedge clk_in);
    valid = '0;
    reset_in = 0;
    model_reset();
    repeat (8) step(4'b0011, 4'b0001, 1, "starve");
    repeat (500)
      step(N'($urandom), N'($urandom) & N'($urandom) & N'($urandom), $urandom_range(0, 3) != 0, "rand");
    @(negedge clk_in);
    #3;
    check("sb drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_request_scheduler.md
MEM_REQUEST_SCHEDULER -- requirements
Module: mem_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQUEST, default 8, number of requester ports (bank miss + writeback sources).
REQ-002 SHALL have parameter SINGLE_REQUEST_WIDTH_IN_BITS, default `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, width of one packet.
REQ-003 SHALL have parameter STARVATION_LIMIT, default 15, wait cycles before a requester is promoted to critical.
REQ-004 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port request_flatted_in  input  NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS  packets; requester i at slice [i*W +: W].
REQ-007 SHALL have port request_valid_flatted_in  input  NUM_REQUEST  per-requester valid.
REQ-008 SHALL have port request_critical_flatted_in  input  NUM_REQUEST  per-requester critical hint.
REQ-009 SHALL have port issue_ack_out  output  NUM_REQUEST  one-hot, one-cycle pulse to granted requester.
REQ-010 SHALL have port request_out  output  SINGLE_REQUEST_WIDTH_IN_BITS  registered granted packet.
REQ-011 SHALL have port request_valid_out  output  1  request_out holds a valid packet.
REQ-012 SHALL have port issue_ack_in  input  1  downstream (memory) accepted request_out.

Function
REQ-013 SHALL implement a two-state FSM: EMPTY (no packet held) and HOLD (packet held, request_valid_out=1).
REQ-014 SHALL grant in a cycle when eligible requests exist and (state EMPTY, or state HOLD with issue_ack_in=1).
REQ-015 SHALL select among critical-and-valid requesters if any exist, else among all valid requesters.
REQ-016 SHALL choose within the selected set round-robin: first index strictly above last-granted pointer, wrapping from NUM_REQUEST-1 to 0.
REQ-017 SHALL assert issue_ack_out[g] combinationally in the grant cycle and capture request slice g into request_out at that clock edge; latency request valid -> request_valid_out = 1 cycle.
REQ-018 SHALL update the last-granted pointer to g only on a grant.
REQ-019 SHALL hold request_out stable while in HOLD without issue_ack_in.
REQ-020 SHALL on issue_ack_in in HOLD with no grant go to EMPTY; with simultaneous grant stay HOLD with new packet (back-to-back, no bubble).
REQ-021 SHALL ignore issue_ack_in while in EMPTY.
REQ-022 SHALL drive issue_ack_out all-zero when no grant occurs; never more than one bit set.
REQ-023 SHALL drive request_out to zero whenever state is EMPTY.

Reset
REQ-024 SHALL on reset_in assertion, asynchronously: state EMPTY, request_valid_out=0, request_out=0, issue_ack_out=0, pointer=NUM_REQUEST-1 (so index 0 wins first), starvation counters=0.
REQ-025 SHALL discard any held packet on reset mid-operation; no ack is issued for it.

Configuration
REQ-026 SHALL compile a starvation guard only when macro MEM_REQUEST_SCHEDULER_STARVATION_GUARD_EN is defined.
REQ-027 SHALL with the macro keep a per-requester counter ($clog2(STARVATION_LIMIT+1) bits): increment (saturating) each cycle valid and not granted, clear on grant or valid low; counter==STARVATION_LIMIT treats requester as critical.
REQ-028 SHALL without the macro contain no counters; criticality comes solely from request_critical_flatted_in.

Verification (NUM_REQUEST=4, STARVATION_LIMIT=3)
REQ-029 SHALL cover: after reset, valid=4'b0101, issue_ack_in=1 always -> grants 0,2,0,2 on consecutive cycles, request_valid_out high from cycle 2 onward.
REQ-030 SHALL cover: valid=4'b1111, critical=4'b1000 -> issue_ack_out=4'b1000 first, then round-robin 0,1,2 once critical drops.
REQ-031 SHALL cover: packet 0xA5 held, issue_ack_in=0 for 5 cycles -> request_out=0xA5 stable, issue_ack_out=0 throughout.
REQ-032 SHALL cover: HOLD, issue_ack_in=1 with valid[1]=1 -> issue_ack_out=4'b0010 same cycle, request_valid_out stays 1 next cycle.
REQ-033 SHALL cover: reset_in asserted mid-HOLD between clock edges -> request_valid_out=0 immediately, no issue_ack_out.
REQ-034 SHALL cover with guard enabled: valid=4'b0011, critical=4'b0001 held constant -> requester 1 granted after exactly 3 ungranted cycles; without guard requester 1 never granted.
